// File: rtl/exc_entry_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : exc_entry_seq
// Purpose  : Exception/interrupt entry and RTE sequencer that sits in front of
//            the control-register file. It takes a trap or an IRQ, flushes
//            EX1..EX3, saves SR/EXSR/SPC/TEA through the regIn* outputs and
//            branches to the vector. It also runs RTE: restores SR and
//            branches to SPC.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock_i          core clock
//   reset_i          synchronous reset, active low
//   hold_i           pipeline stall, freezes the sequencer
//   excReq_i/...     trap request, code, faulting PC, fault address
//   irqReq_i/...     interrupt request, code, resume PC
//   rteReq_i         return-from-exception request
//   regOut*_i        current SR/EXSR/SPC/TEA/VBR from the CR file
//   regIn*_o         next SR/EXSR/SPC/TEA to the CR file
//   pipeFlush_o      flush EX1..EX3
//   branchValid_o    redirect strobe, target on branchPc_o
//   excAck_o         exc/irq accepted (SAVE cycle)
//   rteAck_o         RTE done
//   busy_o           sequencer not idle
//   dblFault_o       sticky: trap taken with IRQs blocked (SR[30]=1)
// ============================================================================
module exc_entry_seq #(
  parameter int unsigned FLUSH_CYC = 3
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        hold_i,
  input  logic        excReq_i,
  input  logic [15:0] excCode_i,
  input  logic [47:0] excPc_i,
  input  logic [63:0] excTea_i,
  input  logic        irqReq_i,
  input  logic [15:0] irqCode_i,
  input  logic [47:0] irqPc_i,
  input  logic        rteReq_i,
  input  logic [63:0] regOutSr_i,
  input  logic [63:0] regOutExsr_i,
  input  logic [47:0] regOutSpc_i,
  input  logic [63:0] regOutTea_i,
  input  logic [47:0] regOutVbr_i,
  output logic [63:0] regInSr_o,
  output logic [63:0] regInExsr_o,
  output logic [47:0] regInSpc_o,
  output logic [63:0] regInTea_o,
  output logic        pipeFlush_o,
  output logic        branchValid_o,
  output logic [47:0] branchPc_o,
  output logic        excAck_o,
  output logic        rteAck_o,
  output logic        busy_o,
  output logic        dblFault_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_SAVE  = 3'd2,
    ST_VECT  = 3'd3,
    ST_RTE   = 3'd4
  } state_e;

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYC);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q,   cnt_d;
  logic [15:0] code_q,  code_d;
  logic [47:0] pc_q,    pc_d;
  logic [63:0] tea_q,   tea_d;
  logic        dbl_q,   dbl_d;

  // An IRQ is only taken when neither block-IRQ nor ISR-active is set.
  logic irq_ok;
  assign irq_ok = irqReq_i & ~regOutSr_i[30] & ~regOutSr_i[28];

  // Low half of EXSR is never consumed; RTE restores only its upper half.
  logic unused_exsr;
  assign unused_exsr = ^regOutExsr_i[31:0];

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      pc_q    <= '0;
      tea_q   <= '0;
      dbl_q   <= 1'b0;
    end else if (!hold_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      tea_q   <= tea_d;
      dbl_q   <= dbl_d;
    end
  end

  // Next-state and capture logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    pc_d    = pc_q;
    tea_d   = tea_q;
    dbl_d   = dbl_q;
    case (state_q)
      ST_IDLE: begin
        if (excReq_i) begin
          // A trap while IRQs are blocked is a double fault: fixed code.
          code_d  = regOutSr_i[30] ? 16'h8000 : excCode_i;
          dbl_d   = dbl_q | regOutSr_i[30];
          pc_d    = excPc_i;
          tea_d   = excTea_i;
          cnt_d   = 3'd1;
          state_d = ST_DRAIN;
        end else if (irq_ok) begin
          code_d  = irqCode_i;
          pc_d    = irqPc_i;
          tea_d   = '0;
          cnt_d   = 3'd1;
          state_d = ST_DRAIN;
        end else if (rteReq_i) begin
          state_d = ST_RTE;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = ST_SAVE;
        end else begin
          cnt_d = 3'(cnt_q + 3'd1);
        end
      end
      ST_SAVE: state_d = ST_VECT;
      ST_VECT: state_d = ST_IDLE;
      ST_RTE:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the registered state so a held state keeps its
  // outputs asserted. While reset is low everything reads as idle.
  always_comb begin
    regInSr_o     = regOutSr_i;
    regInExsr_o   = regOutExsr_i;
    regInSpc_o    = regOutSpc_i;
    regInTea_o    = regOutTea_i;
    pipeFlush_o   = 1'b0;
    branchValid_o = 1'b0;
    branchPc_o    = '0;
    excAck_o      = 1'b0;
    rteAck_o      = 1'b0;
    busy_o        = 1'b0;
    dblFault_o    = 1'b0;
    if (reset_i) begin
      busy_o     = (state_q != ST_IDLE);
      dblFault_o = dbl_q;
      case (state_q)
        ST_DRAIN: pipeFlush_o = 1'b1;
        ST_SAVE: begin
          pipeFlush_o = 1'b1;
          excAck_o    = 1'b1;
          regInSr_o   = regOutSr_i | 64'h0000_0000_7000_0000;
          regInExsr_o = {regOutSr_i[31:0], 16'h0000, code_q};
          regInSpc_o  = pc_q;
          regInTea_o  = tea_q;
        end
        ST_VECT: begin
          branchValid_o = 1'b1;
          // Vector slot = code[15:12] * 8, wrapping in the 48-bit space.
          branchPc_o    = regOutVbr_i + {41'd0, code_q[15:12], 3'b000};
        end
        ST_RTE: begin
          regInSr_o     = {regOutSr_i[63:32], regOutExsr_i[63:32]};
          branchValid_o = 1'b1;
          branchPc_o    = regOutSpc_i;
          rteAck_o      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
